mips_multicycle_core: RTL

//   Multi-cycle MIPS-subset core: datapath plus internal control FSM sharing one memory port.

---
 rtl/mips_multicycle_core.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_core.sv
// rtl/mips_multicycle_core.sv - multi-cycle MIPS-subset core with one shared memory port
//
// Purpose: datapath and control FSM for a MIPS subset. The subset is add/sub/and/or/slt/jr,
// addi/lw/sw/beq and j/jal. Instruction fetch and data access share a single req/ready port.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   mem_req, mem_we   transaction request and direction (1 = write)
//   mem_adr           word-aligned byte address (low ADDR_W bits)
//   mem_wdata         store data
//   mem_rdata         read data, captured on the req & ready edge
//   mem_ready         memory completes the pending transaction this cycle
//   halted            core is parked in HALT
//   pc_dbg            current PC register
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned ADDR_W          = 32,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic [31:0]       pc_dbg
);
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J  = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08, OP_LW = 6'h23, OP_SW  = 6'h2B;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A, F_JR  = 6'h08;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD,
    S_MEM_WR, S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  localparam state_t ILLEGAL_NXT = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;

  state_t      state, state_nxt;
  logic [31:0] pc, ir, a_reg, b_reg, tgt, alu_out, mdr;
  logic [31:0] rf [0:31];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, wb_idx;
  logic [31:0] imm_sx, alu_r, addr_full;
  logic        r_alu_ok;

  assign op       = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign imm_sx   = {{16{ir[15]}}, ir[15:0]};
  assign r_alu_ok = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
  assign wb_idx   = (op == OP_RTYPE) ? rd : rt;

  // Only FETCH uses the PC as address; data accesses use the computed effective address.
  // The low two bits are cleared so misaligned lw/sw land on the word boundary.
  assign addr_full = (state == S_FETCH) ? pc : alu_out;
  assign mem_adr   = addr_full[ADDR_W-1:0] & ~ADDR_W'(3);
  assign mem_wdata = b_reg;
  assign pc_dbg    = pc;

  always_comb begin
    alu_r = a_reg + b_reg;
    case (funct)
      F_SUB:   alu_r = a_reg - b_reg;
      F_AND:   alu_r = a_reg & b_reg;
      F_OR:    alu_r = a_reg | b_reg;
      F_SLT:   alu_r = {31'd0, $signed(a_reg) < $signed(b_reg)};
      default: ;
    endcase
  end

  // Next state and memory-port controls. The request is masked by rst so a pending
  // transfer is dropped in the same cycle reset is asserted.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    halted    = 1'b0;
    case (state)
      S_FETCH:    if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_RTYPE: begin
            if (funct == F_JR)  state_nxt = S_JUMP;
            else if (r_alu_ok)  state_nxt = S_EXEC_R;
            else                state_nxt = ILLEGAL_NXT;
          end
          OP_ADDI:      state_nxt = S_EXEC_I;
          OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J, OP_JAL: state_nxt = S_JUMP;
          default:      state_nxt = ILLEGAL_NXT;
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_nxt = S_WB_ALU;
      S_MEM_ADDR: state_nxt = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_nxt = S_WB_MEM;
      S_MEM_WR:   if (mem_ready) state_nxt = S_FETCH;
      S_HALT:     state_nxt = S_HALT;
      default:    state_nxt = S_FETCH;
    endcase
    if (!rst) begin
      mem_req = state inside {S_FETCH, S_MEM_RD, S_MEM_WR};
      mem_we  = (state == S_MEM_WR);
      halted  = (state == S_HALT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      tgt     <= '0;
      alu_out <= '0;
      mdr     <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            ir <= mem_rdata;
            pc <= pc + 32'd4;
          end
        end
        S_DECODE: begin
          a_reg <= rf[rs];
          b_reg <= rf[rt];
          tgt   <= pc + (imm_sx << 2);
        end
        S_EXEC_R:             alu_out <= alu_r;
        S_EXEC_I, S_MEM_ADDR: alu_out <= a_reg + imm_sx;
        S_WB_ALU:             if (wb_idx != 5'd0) rf[wb_idx] <= alu_out;
        S_MEM_RD:             if (mem_ready) mdr <= mem_rdata;
        S_WB_MEM:             if (rt != 5'd0) rf[rt] <= mdr;
        S_BRANCH:             if (a_reg == b_reg) pc <= tgt;
        S_JUMP: begin
          if (op == OP_RTYPE) begin
            pc <= a_reg;
          end else begin
            pc <= {pc[31:28], ir[25:0], 2'b00};
            // pc already holds the return address (instruction address + 4)
            if (op == OP_JAL) rf[31] <= pc;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
